apple_spawner: RTL and testbench

- Parametrised successor to the single-apple generator in the snake game.
- Holds up to NUM_APPLES apple positions on a GRID_W x GRID_H board.
- Detects when the snake head eats an apple and respawns that apple at a pseudo-random free cell, rejecting cells occupied by the body or by other apples.
- Sits between the snake body tracker and the VGA pixel renderer; answers per-pixel "apple here" queries.

---
 rtl/snake_pkg.sv | 23 ++
 rtl/lfsr16.sv | 31 +++
 rtl/apple_spawner.sv | 195 +++++++++++++++++++
 tb/tb_apple_spawner.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and default dimensions for the snake game datapath.
// Cells are packed {x,y}, with x in the upper half.
package snake_pkg;

    localparam int DEF_GRID_W     = 16;
    localparam int DEF_GRID_H     = 16;
    localparam int DEF_MAX_LENGTH = 50;
    localparam int DEF_CW         = 4;

    typedef logic [2*DEF_CW-1:0] cell_t;

    typedef enum logic [1:0] {
        IDLE,
        PICK,
        SCAN,
        CHECK
    } spawn_state_t;

    function automatic logic in_grid(input int cx, input int cy, input int w, input int h);
        return (cx < w) && (cy < h);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR (taps 16,14,13,11), steps every cycle.
// Latency: new value each cycle; no backpressure.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    always_comb begin
        q_d = q_q >> 1;
        if (q_q[0]) begin
            q_d = q_d ^ 16'hB400;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/apple_spawner.sv
// Tracks NUM_APPLES apples, detects eats and respawns them at random free cells.
// Spawn takes 1 PICK + body_len SCAN + 1 CHECK cycles minimum; retries are unbounded.
module apple_spawner
    import snake_pkg::*;
#(
    parameter int          GRID_W     = DEF_GRID_W,
    parameter int          GRID_H     = DEF_GRID_H,
    parameter int          NUM_APPLES = 3,
    parameter int          MAX_LENGTH = DEF_MAX_LENGTH,
    parameter int          CW         = DEF_CW,
    parameter logic [15:0] SEED       = 16'hACE1,
    localparam int         LW         = $clog2(MAX_LENGTH + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           move_tick,
    input  logic [2*CW-1:0]                head,
    input  logic [MAX_LENGTH*2*CW-1:0]     body,
    input  logic [LW-1:0]                  body_len,
    input  logic [CW-1:0]                  x,
    input  logic [CW-1:0]                  y,
    output logic                           apple,
    output logic                           eaten,
    output logic [NUM_APPLES*2*CW-1:0]     apple_pos,
    output logic [NUM_APPLES-1:0]          apple_valid,
    output logic                           busy
);

    localparam int SW = (NUM_APPLES > 1) ? $clog2(NUM_APPLES) : 1;

    typedef logic [2*CW-1:0] cell_w_t;

    logic [15:0]                      lfsr;
    logic                             lfsr_unused;
    spawn_state_t                     state_q, state_d;
    logic [NUM_APPLES-1:0]            pending_q, pending_d;
    logic [NUM_APPLES-1:0]            valid_q, valid_d;
    logic [NUM_APPLES-1:0][2*CW-1:0]  pos_q, pos_d;
    cell_w_t                          cand_q, cand_d, cand_pick;
    logic [SW-1:0]                    slot_q, slot_d;
    logic [SW-1:0]                    pend_lo, eat_k;
    logic [LW-1:0]                    idx_q, idx_d, eff_len;
    logic                             eaten_q, eaten_d;
    logic                             apple_q, apple_d;
    logic                             eat_hit, scan_hit, check_hit, spawn_wr;
    logic [MAX_LENGTH-1:0][2*CW-1:0]  body_cells;

    lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr)
    );

    assign lfsr_unused = ^lfsr;
    assign body_cells  = body;
    assign cand_pick   = {lfsr[CW-1:0], lfsr[2*CW-1:CW]};
    assign eff_len     = (int'(body_len) > MAX_LENGTH) ? LW'(MAX_LENGTH) : body_len;

    // Descending loops so the lowest matching index wins.
    always_comb begin
        eat_hit = 1'b0;
        eat_k   = '0;
        pend_lo = '0;
        for (int i = NUM_APPLES - 1; i >= 0; i--) begin
            if (valid_q[i] && pos_q[i] == head) begin
                eat_hit = move_tick;
                eat_k   = SW'(i);
            end
            if (pending_q[i]) begin
                pend_lo = SW'(i);
            end
        end
    end

    always_comb begin
        scan_hit = 1'b0;
        for (int i = 0; i < MAX_LENGTH; i++) begin
            if (idx_q == LW'(i) && body_cells[i] == cand_q) begin
                scan_hit = 1'b1;
            end
        end
    end

    always_comb begin
        check_hit = (head == cand_q);
        for (int i = 0; i < NUM_APPLES; i++) begin
            if (valid_q[i] && SW'(i) != slot_q && pos_q[i] == cand_q) begin
                check_hit = 1'b1;
            end
        end
    end

    always_comb begin
        apple_d = 1'b0;
        for (int i = 0; i < NUM_APPLES; i++) begin
            if (valid_q[i] && pos_q[i] == {x, y}) begin
                apple_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        slot_d   = slot_q;
        idx_d    = idx_q;
        spawn_wr = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pending_q != '0) begin
                    state_d = PICK;
                end
            end
            PICK: begin
                slot_d = pend_lo;
                if (in_grid(int'(lfsr[CW-1:0]), int'(lfsr[2*CW-1:CW]), GRID_W, GRID_H)) begin
                    cand_d  = cand_pick;
                    idx_d   = '0;
                    state_d = (eff_len == '0) ? CHECK : SCAN;
                end
            end
            SCAN: begin
                // eff_len may shrink under us if the body changes mid-scan.
                if (idx_q >= eff_len) begin
                    state_d = CHECK;
                end else if (scan_hit) begin
                    state_d = PICK;
                end else if (int'(idx_q) + 1 >= int'(eff_len)) begin
                    state_d = CHECK;
                end else begin
                    idx_d = idx_q + LW'(1);
                end
            end
            CHECK: begin
                if (check_hit) begin
                    state_d = PICK;
                end else begin
                    spawn_wr = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = PICK;
        endcase
    end

    // The slot being spawned is never valid, so it can never be the eaten one.
    always_comb begin
        valid_d   = valid_q;
        pending_d = pending_q;
        pos_d     = pos_q;
        eaten_d   = eat_hit;
        if (spawn_wr) begin
            valid_d[slot_q]   = 1'b1;
            pending_d[slot_q] = 1'b0;
            pos_d[slot_q]     = cand_q;
        end
        if (eat_hit) begin
            valid_d[eat_k]   = 1'b0;
            pending_d[eat_k] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= PICK;
            pending_q <= '1;
            valid_q   <= '0;
            pos_q     <= '0;
            cand_q    <= '0;
            slot_q    <= '0;
            idx_q     <= '0;
            eaten_q   <= 1'b0;
            apple_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            valid_q   <= valid_d;
            pos_q     <= pos_d;
            cand_q    <= cand_d;
            slot_q    <= slot_d;
            idx_q     <= idx_d;
            eaten_q   <= eaten_d;
            apple_q   <= apple_d;
        end
    end

    assign apple       = apple_q;
    assign eaten       = eaten_q;
    assign apple_pos   = pos_q;
    assign apple_valid = valid_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_apple_spawner.sv
// Directed bench for apple_spawner: seeded first spawns, eats, range, body avoidance, reset.
// Expected first-spawn cells come from the LFSR sequence from 16'hACE1 worked by hand.
module tb_apple_spawner;

    logic         clk = 1'b0;
    logic         reset;
    logic         move_tick, move_tick_r;
    logic [7:0]   head, head_r;
    logic [399:0] body, body_r;
    logic [5:0]   body_len, body_len_r;
    logic [3:0]   x, y;
    logic         apple, eaten, busy;
    logic [23:0]  apple_pos;
    logic [2:0]   apple_valid;
    logic         apple_r, eaten_r, busy_r;
    logic [23:0]  apple_pos_r;
    logic [2:0]   apple_valid_r;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    apple_spawner u_dut (
        .clk(clk), .reset(reset), .move_tick(move_tick), .head(head),
        .body(body), .body_len(body_len), .x(x), .y(y),
        .apple(apple), .eaten(eaten), .apple_pos(apple_pos),
        .apple_valid(apple_valid), .busy(busy)
    );

    apple_spawner #(.GRID_W(10), .GRID_H(12)) u_dut_r (
        .clk(clk), .reset(reset), .move_tick(move_tick_r), .head(head_r),
        .body(body_r), .body_len(body_len_r), .x(x), .y(y),
        .apple(apple_r), .eaten(eaten_r), .apple_pos(apple_pos_r),
        .apple_valid(apple_valid_r), .busy(busy_r)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Seed ACE1 -> PICK draws s0=ACE1 (1,14), s3=389C (12,9), s6=B313 (3,1).
    task automatic first_spawn(input string tag);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk({tag, "_valid_e2"}, apple_valid, 3'b001);
        chk({tag, "_pos0_e2"}, apple_pos[7:0], 8'h1E);
        repeat (6) @(negedge clk);
        chk({tag, "_valid_e8"}, apple_valid, 3'b111);
        chk({tag, "_pos_e8"}, apple_pos, 24'h31C91E);
        chk({tag, "_busy_e8"}, busy, 1'b0);
    endtask

    task automatic wait_all(output bit ok, output int busy_cyc);
        ok = 1'b0;
        busy_cyc = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!busy && apple_valid == 3'b111) begin
                ok = 1'b1;
                break;
            end
            if (busy) busy_cyc++;
            @(negedge clk);
        end
    endtask

    task automatic wait_all_r(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!busy_r && apple_valid_r == 3'b111) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    function automatic bit on_body(input logic [7:0] c);
        return (c[3:0] < 4'd3) || (c[3:0] == 4'd3 && c[7:4] < 4'd2);
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int bc, min_bc, bad, eats, tmo, first;
        logic [7:0] p0, p2, np;
        logic e1, e2;

        reset = 1'b1;
        move_tick = 1'b0;   move_tick_r = 1'b0;
        head = 8'hFF;       head_r = 8'hFF;
        body = '0;          body_r = '0;
        body_len = '0;      body_len_r = '0;
        x = '0;             y = '0;

        repeat (2) @(negedge clk);
        chk("rst_valid", apple_valid, 3'b000);
        chk("rst_pos", apple_pos, 24'h0);
        chk("rst_apple", apple, 1'b0);
        chk("rst_eaten", eaten, 1'b0);
        chk("rst_busy", busy, 1'b1);

        first_spawn("boot");

        // Pixel query, one-cycle registered latency.
        x = 4'd3; y = 4'd1;
        @(negedge clk);
        chk("pix_3_1", apple, 1'b1);
        x = 4'd3; y = 4'd2;
        @(negedge clk);
        chk("pix_3_2", apple, 1'b0);
        x = 4'd12; y = 4'd9;
        #1;
        chk("pix_latency", apple, 1'b0);
        @(negedge clk);
        chk("pix_12_9", apple, 1'b1);

        move_tick = 1'b1;
        @(negedge clk);
        chk("no_eat_miss", eaten, 1'b0);
        move_tick = 1'b0;

        // Eat apple 1 at (12,9); head stays there during respawn.
        head = 8'hC9;
        move_tick = 1'b1;
        @(negedge clk);
        move_tick = 1'b0;
        chk("eat1_pulse", eaten, 1'b1);
        chk("eat1_valid", apple_valid, 3'b101);
        @(negedge clk);
        chk("eat1_pulse_end", eaten, 1'b0);
        wait_all(ok, bc);
        chk("eat1_respawn_done", ok, 1'b1);
        chk("eat1_ne_old", apple_pos[15:8] != 8'hC9, 1'b1);
        chk("eat1_ne_a0", apple_pos[15:8] != apple_pos[7:0], 1'b1);
        chk("eat1_ne_a2", apple_pos[15:8] != apple_pos[23:16], 1'b1);
        chk("eat1_keep_a0", apple_pos[7:0], 8'h1E);
        chk("eat1_keep_a2", apple_pos[23:16], 8'h31);

        // 10x12 board: every respawn must stay in range.
        bad = 0; eats = 0; tmo = 0;
        for (int r = 0; r < 300; r++) begin
            wait_all_r(ok);
            if (!ok) begin tmo++; break; end
            for (int k = 0; k < 3; k++) begin
                np = apple_pos_r[k*8 +: 8];
                if (np[7:4] >= 4'd10 || np[3:0] >= 4'd12) bad++;
            end
            head_r = apple_pos_r[7:0];
            move_tick_r = 1'b1;
            @(negedge clk);
            move_tick_r = 1'b0;
            if (eaten_r) eats++;
        end
        chk("range_timeout", tmo, 0);
        chk("range_bad", bad, 0);
        chk("range_eats", eats, 300);

        // Body of 50 cells: rows y=0..2 fully, plus (0,3),(1,3).
        for (int i = 0; i < 50; i++) begin
            body[i*8 +: 8] = {4'(i % 16), 4'(i / 16)};
        end
        body_len = 6'd50;
        bad = 0; eats = 0; tmo = 0; min_bc = 100000;
        wait_all(ok, bc);
        for (int r = 0; r < 100; r++) begin
            head = apple_pos[7:0];
            move_tick = 1'b1;
            @(negedge clk);
            move_tick = 1'b0;
            if (eaten) eats++;
            wait_all(ok, bc);
            if (!ok) begin tmo++; break; end
            if (bc < min_bc) min_bc = bc;
            if (on_body(apple_pos[7:0])) bad++;
        end
        chk("body_timeout", tmo, 0);
        chk("body_eats", eats, 100);
        chk("body_hits", bad, 0);
        chk("body_scan_min", min_bc >= 52, 1'b1);

        // Two eats on back-to-back ticks: apple 0 then apple 2.
        p0 = apple_pos[7:0];
        p2 = apple_pos[23:16];
        head = p0;
        move_tick = 1'b1;
        @(negedge clk);
        e1 = eaten;
        head = p2;
        @(negedge clk);
        e2 = eaten;
        move_tick = 1'b0;
        chk("dbl_eaten", {e1, e2}, 2'b11);
        chk("dbl_valid", apple_valid, 3'b010);
        first = -1;
        for (int i = 0; i < 3000; i++) begin
            if (first < 0 && apple_valid[0]) first = 0;
            else if (first < 0 && apple_valid[2]) first = 2;
            if (apple_valid == 3'b111 && !busy) break;
            @(negedge clk);
        end
        chk("dbl_order", first, 0);
        chk("dbl_done", apple_valid, 3'b111);

        // Reset mid-SCAN.
        head = apple_pos[7:0];
        move_tick = 1'b1;
        @(negedge clk);
        move_tick = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_busy_pre", busy, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", apple_valid, 3'b000);
        chk("mid_rst_busy", busy, 1'b1);
        chk("mid_rst_pos", apple_pos, 24'h0);
        body = '0;
        body_len = '0;
        head = 8'hFF;
        first_spawn("rerun");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
